// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit owning HI/LO.
// Result is computed at launch, held pending, committed after N cycles.
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       way,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;
  logic             skip_q, skip_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2*WIDTH-1:0] sprod, uprod, acc;
  logic [WIDTH-1:0]   ua, ub, qm, rm, quo, rem;
  logic               sgn, neg_q, neg_r, bzero;

  // Datapath: products, accumulator and sign-magnitude division
  always_comb begin
    acc   = {hi_q, lo_q};
    sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    sgn   = (way == 3'b011);
    neg_q = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    neg_r = sgn & a[WIDTH-1];
    ua    = (sgn & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    ub    = (sgn & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    bzero = (b == '0);
    qm    = bzero ? '0 : ua / ub;
    rm    = bzero ? '0 : ua % ub;
    quo   = neg_q ? (~qm + WIDTH'(1)) : qm;
    rem   = neg_r ? (~rm + WIDTH'(1)) : rm;
  end

  // Next-state: launch, countdown, commit and HI/LO writes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    skip_d  = skip_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !req && way != 3'b000) begin
          state_d = RUN;
          skip_d  = 1'b0;
          cnt_d   = CW'(MULT_CYCLES);
          case (way)
            3'b001: {phi_d, plo_d} = sprod;
            3'b010: {phi_d, plo_d} = uprod;
            3'b101: {phi_d, plo_d} = acc + sprod;
            3'b110: {phi_d, plo_d} = acc + uprod;
            3'b111: {phi_d, plo_d} = acc - sprod;
            default: begin
              {phi_d, plo_d} = {rem, quo};
              skip_d         = bzero;
              cnt_d          = CW'(DIV_CYCLES);
            end
          endcase
        end
        if (!req && hi_we) hi_d = a;
        if (!req && lo_we) lo_d = a;
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (!skip_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      skip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      skip_q  <= skip_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors, corner sequences and
// random traffic against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int W  = 32;
  localparam int NM = 5;
  localparam int ND = 10;

  logic          clk = 1'b0;
  logic          reset, start, hi_we, lo_we, req;
  logic [2:0]    way;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .way(way),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .req(req),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // reference model state
  longint        cyc = 0;
  longint        m_end = 0;
  bit            m_act = 0, m_done = 0, m_dz = 0;
  logic [W-1:0]  m_hi = 0, m_lo = 0;
  logic [2*W-1:0] m_p = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic void calc(input logic [2:0] w,
      input logic [W-1:0] x, input logic [W-1:0] y,
      input logic [2*W-1:0] acc, output logic [2*W-1:0] r,
      output bit dz, output int n);
    longint sp;
    longint unsigned up;
    int sx, sy, q, rm;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = {32'h0, x} * {32'h0, y};
    dz = 0;
    n  = NM;
    r  = acc;
    case (w)
      3'd1: r = sp;
      3'd2: r = up;
      3'd5: r = acc + sp;
      3'd6: r = acc + up;
      3'd7: r = acc - sp;
      3'd3: begin
        n = ND; sx = x; sy = y;
        if (y == 0) dz = 1;
        else if (x == 32'h80000000 && sy == -1)
          r = {32'h0, 32'h80000000};
        else begin q = sx / sy; rm = sx % sy; r = {rm, q}; end
      end
      default: begin
        n = ND;
        if (y == 0) dz = 1;
        else r = {x % y, x / y};
      end
    endcase
  endfunction

  task automatic model_step();
    int n;
    cyc++;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_act = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_act) begin
        if (cyc == m_end) begin
          m_act = 0; m_done = 1;
          if (!m_dz) {m_hi, m_lo} = m_p;
        end
      end else if (!req) begin
        if (start && way != 0) begin
          calc(way, a, b, {m_hi, m_lo}, m_p, m_dz, n);
          m_act = 1;
          m_end = cyc + n;
        end
        if (hi_we) m_hi = a;
        if (lo_we) m_lo = a;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_busy", {63'h0, busy}, {63'h0, m_act});
    chk("m_done", {63'h0, done}, {63'h0, m_done});
    chk("m_hi", {32'h0, hi}, {32'h0, m_hi});
    chk("m_lo", {32'h0, lo}, {32'h0, m_lo});
  endtask

  task automatic idle_in();
    start = 0; hi_we = 0; lo_we = 0; req = 0; reset = 0;
    way = 0; a = 0; b = 0;
  endtask

  task automatic preset(input logic [W-1:0] h, input logic [W-1:0] l);
    idle_in(); hi_we = 1; a = h; tick();
    idle_in(); lo_we = 1; a = l; tick();
    idle_in();
  endtask

  typedef struct {
    logic [2:0]   w;
    logic [W-1:0] x, y, ph, pl, eh, el;
  } vec_t;

  vec_t vt[10];

  initial begin
    int n;
    vt[0] = '{3'd1, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1] = '{3'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[2] = '{3'd4, 32'd7, 32'd2, 0, 0, 32'd1, 32'd3};
    vt[3] = '{3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22};
    vt[4] = '{3'd6, 32'd1, 32'd1, 0, 32'hFFFFFFFF, 32'd1, 32'd0};
    vt[5] = '{3'd7, 32'd1, 32'd1, 32'd1, 0, 0, 32'hFFFFFFFF};
    vt[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1, 1, 0, 32'h80000000};
    vt[7] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0,
              32'hFFFFFFFE, 32'h00000001};
    vt[8] = '{3'd5, 32'hFFFFFFFF, 32'd1, 0, 32'd5, 0, 32'd4};
    vt[9] = '{3'd7, 32'd2, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA};

    idle_in();
    reset = 1;
    tick(); tick();
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    idle_in();

    for (int i = 0; i < 10; i++) begin
      preset(vt[i].ph, vt[i].pl);
      n = (vt[i].w == 3'd3 || vt[i].w == 3'd4) ? ND : NM;
      start = 1; way = vt[i].w; a = vt[i].x; b = vt[i].y;
      tick();
      idle_in();
      for (int k = 0; k < n; k++) begin
        chk("v_busy", {63'h0, busy}, 64'h1);
        tick();
      end
      chk("v_busy_end", {63'h0, busy}, 64'h0);
      chk("v_done", {63'h0, done}, 64'h1);
      chk("v_hi", {32'h0, hi}, {32'h0, vt[i].eh});
      chk("v_lo", {32'h0, lo}, {32'h0, vt[i].el});
      tick();
      chk("v_done_off", {63'h0, done}, 64'h0);
    end

    // start with req is dropped
    preset(32'h55, 32'h66);
    start = 1; req = 1; way = 3'd1; a = 3; b = 3;
    tick();
    idle_in();
    chk("req_busy", {63'h0, busy}, 64'h0);
    tick();
    chk("req_hi", {32'h0, hi}, 64'h55);
    chk("req_lo", {32'h0, lo}, 64'h66);

    // way 000 ignored
    start = 1; way = 3'd0; a = 9; b = 9;
    tick();
    idle_in();
    chk("nop_busy", {63'h0, busy}, 64'h0);

    // second start and mtlo while busy ignored; req in RUN harmless
    start = 1; way = 3'd1; a = 2; b = 3;
    tick();
    idle_in();
    start = 1; way = 3'd3; a = 100; b = 7; lo_we = 1; req = 0;
    tick();
    idle_in(); req = 1;
    for (int k = 0; k < NM; k++) tick();
    idle_in();
    chk("hz_busy", {63'h0, busy}, 64'h0);
    chk("hz_hi", {32'h0, hi}, 64'h0);
    chk("hz_lo", {32'h0, lo}, 64'h6);

    // mthi with maddu: accumulates onto pre-write value
    preset(32'h0, 32'd10);
    start = 1; way = 3'd6; a = 2; b = 3; hi_we = 1;
    tick();
    idle_in();
    chk("wr_hi_now", {32'h0, hi}, 64'h2);
    for (int k = 0; k < NM; k++) tick();
    chk("wr_hi", {32'h0, hi}, 64'h0);
    chk("wr_lo", {32'h0, lo}, 64'd16);

    // reset mid divide
    preset(32'h77, 32'h88);
    start = 1; way = 3'd3; a = 50; b = 3;
    tick();
    idle_in();
    tick(); tick(); tick();
    reset = 1;
    tick();
    idle_in();
    chk("mr_busy", {63'h0, busy}, 64'h0);
    chk("mr_hi", {32'h0, hi}, 64'h0);
    chk("mr_lo", {32'h0, lo}, 64'h0);
    for (int k = 0; k < ND + 2; k++) begin
      tick();
      chk("mr_nodone", {63'h0, done}, 64'h0);
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      idle_in();
      start = ($urandom_range(0, 3) == 0);
      way   = 3'($urandom_range(0, 7));
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      req   = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: a = 32'h80000000;
        1: a = 32'($urandom_range(0, 9));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(0, 9));
        default: b = $urandom;
      endcase
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Parametrised multiply/divide unit with its own sequencing control, owning the HI/LO registers for the pipelined MIPS core.
- Accepts start/way/HI-LO write commands from the E-stage control decode and runs multi-cycle signed/unsigned mult, div and multiply-accumulate.
- Exposes busy for the hazard unit to stall md-class instructions.
- Adds configurable latency and width, accumulate modes, and exception cancellation.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub; minimum 1.
- DIV_CYCLES, 10, busy cycles for div/divu; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  launch the operation selected by way.
- way  in  3  001 mult, 010 multu, 011 div, 100 divu, 101 madd, 110 maddu, 111 msub; 000 no-op.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- hi_we  in  1  mthi: HI <= a.
- lo_we  in  1  mtlo: LO <= a.
- req  in  1  exception/interrupt in flight; suppresses start, hi_we and lo_we this cycle.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO commit from an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- States and transitions:
  - IDLE -> RUN when start & !req & way!=000 at a rising edge. The result is computed from a, b and the current HI/LO, then latched into pending registers. The counter loads MULT_CYCLES or DIV_CYCLES.
  - RUN: busy=1 and the counter decrements each cycle.
  - When counter==1, RUN -> IDLE and HI/LO take the pending values. hi/lo show the new values and done=1 in the first cycle after busy falls.
- Latency: start is sampled at edge t. busy is high for exactly N cycles after that edge. Results are visible N cycles after t.
- start with way=000 is ignored.
- Arithmetic:
  - mult/multu: {HI,LO} = a*b as a 2*WIDTH product, signed or unsigned.
  - madd: {HI,LO} += signed a*b. maddu: {HI,LO} += unsigned a*b. msub: {HI,LO} -= signed a*b. All modulo 2^(2*WIDTH).
  - div: LO = quotient truncated toward zero; HI = remainder, carrying the dividend's sign.
  - divu: unsigned quotient and remainder.
  - Divide by zero: the operation runs its full DIV_CYCLES, HI/LO stay unchanged, and done still pulses.
  - Signed MIN/-1: LO = MIN, HI = 0.
- Boundary conditions:
  - start while busy: ignored. The hazard unit must stall; the unit does not queue.
  - hi_we/lo_we while busy: ignored.
  - hi_we/lo_we in IDLE, or in the same cycle as a start: the write applies. A started madd/maddu/msub accumulates onto the pre-write HI/LO.
  - hi_we and lo_we together: both apply.
  - req with start in the same cycle: start is dropped; the unit stays IDLE and busy stays 0.
  - req during RUN: no effect; the operation completes. The instruction has already committed to the unit.
  - reset during RUN: immediately returns to IDLE with busy=0 and HI=LO=0. There is no commit and no done pulse.
- Output timing: hi, lo, busy and done are registered; none has a combinational path from the inputs.

Test Plan:
- Signed mult, N=5: a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulses once.
- Signed div: a=-7, b=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=2 -> LO=3, HI=1.
- Divide by zero: HI=0x11, LO=0x22, then div a=5, b=0 -> 10 busy cycles, done pulses, HI/LO stay 0x11/0x22.
- Accumulate: mthi 0, mtlo 0xFFFFFFFF, then maddu a=1, b=1 -> HI=1, LO=0. Then msub a=1, b=1 -> HI=0, LO=0xFFFFFFFF.
- Hazard and cancellation:
  - start+req with mult 3*3 -> busy stays 0 and HI/LO are unchanged.
  - A second start, or mtlo, during busy -> ignored; the first result commits intact.
- Reset mid-op: start div and assert reset on cycle 4 -> next cycle busy=0, HI=LO=0, and no done pulse follows.
